// File: rtl/led_status_ctrl.sv
// N-channel front-panel LED controller: per-LED off/on/blink/event-stretch modes with
// per-LED polarity, configured over the clk_usb register bus.
module led_status_ctrl #(
    parameter int           pNUM_LEDS     = 4,
    parameter int           pCNT_WIDTH    = 25,
    parameter int           pTICK_LOG2    = 10,
    parameter int           pBYTECNT_SIZE = 7,
    parameter logic [5:0]   pADDR_MODE    = 6'h30,
    parameter logic [5:0]   pADDR_INVERT  = 6'h31,
    parameter logic [5:0]   pADDR_STRETCH = 6'h32,
    parameter logic [5:0]   pADDR_BLINK   = 6'h33
) (
    input  logic                     clk_usb,
    input  logic                     reset_n,
    input  logic [5:0]               reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic [7:0]               reg_datai,
    output logic [7:0]               reg_datao,
    input  logic                     reg_read,
    input  logic                     reg_write,
    input  logic                     reg_addrvalid,
    input  logic [pNUM_LEDS-1:0]     event_i,
    output logic [pNUM_LEDS-1:0]     led_o
);

    localparam int MODE_W = 2 * pNUM_LEDS;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_STRETCH = 2'd3
    } led_mode_t;

    logic [pCNT_WIDTH-1:0] cnt;
    logic [pCNT_WIDTH-1:0] cnt_shifted;
    logic [MODE_W-1:0]     mode;
    logic [MODE_W-1:0]     mode_next;
    logic [pNUM_LEDS-1:0]  invert;
    logic [pNUM_LEDS-1:0]  invert_next;
    logic [15:0]           stretch_len;
    logic [4:0]            blink_sel;
    logic [4:0]            blink_eff;
    logic [15:0]           scnt [pNUM_LEDS];
    logic [pNUM_LEDS-1:0]  raw;
    logic                  tick;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_ok = reg_write & reg_addrvalid;
    assign rd_ok = reg_read & reg_addrvalid;
    assign tick  = (cnt[pTICK_LOG2-1:0] == '0);

    // Out-of-range blink selections saturate to the counter MSB.
    always_comb begin
        blink_eff = blink_sel;
        if (int'(blink_sel) > pCNT_WIDTH - 1)
            blink_eff = 5'(pCNT_WIDTH - 1);
        cnt_shifted = cnt >> blink_eff;
    end

    always_comb begin
        mode_next   = mode;
        invert_next = invert;
        if (wr_ok && reg_address == pADDR_MODE) begin
            for (int j = 0; j < MODE_W; j++)
                if (int'(reg_bytecnt) == j / 8)
                    mode_next[j] = reg_datai[3'(j % 8)];
        end
        if (wr_ok && reg_address == pADDR_INVERT) begin
            for (int j = 0; j < pNUM_LEDS; j++)
                if (int'(reg_bytecnt) == j / 8)
                    invert_next[j] = reg_datai[3'(j % 8)];
        end
    end

    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            cnt         <= '0;
            mode        <= {pNUM_LEDS{MODE_BLINK}};
            invert      <= '0;
            stretch_len <= 16'd100;
            blink_sel   <= 5'(pCNT_WIDTH - 1);
        end else begin
            cnt    <= cnt + 1'b1;
            mode   <= mode_next;
            invert <= invert_next;
            if (wr_ok && reg_address == pADDR_STRETCH) begin
                if (reg_bytecnt == '0)
                    stretch_len[7:0] <= reg_datai;
                else if (reg_bytecnt == pBYTECNT_SIZE'(1))
                    stretch_len[15:8] <= reg_datai;
            end
            if (wr_ok && reg_address == pADDR_BLINK && reg_bytecnt == '0)
                blink_sel <= reg_datai[4:0];
        end
    end

    // Leaving STRETCH wins over a same-cycle event; an event reload wins over a tick.
    always_ff @(posedge clk_usb) begin
        for (int i = 0; i < pNUM_LEDS; i++) begin
            if (!reset_n)
                scnt[i] <= '0;
            else if (mode[2*i +: 2] == MODE_STRETCH && mode_next[2*i +: 2] != MODE_STRETCH)
                scnt[i] <= '0;
            else if (mode[2*i +: 2] == MODE_STRETCH && event_i[i])
                scnt[i] <= stretch_len;
            else if (tick && scnt[i] != '0)
                scnt[i] <= scnt[i] - 16'd1;
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < pNUM_LEDS; i++) begin
            case (led_mode_t'(mode[2*i +: 2]))
                MODE_OFF:     raw[i] = 1'b0;
                MODE_ON:      raw[i] = 1'b1;
                MODE_BLINK:   raw[i] = cnt_shifted[0];
                MODE_STRETCH: raw[i] = event_i[i] | (scnt[i] != '0);
                default:      raw[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_usb) begin
        if (!reset_n)
            led_o <= '0;
        else
            led_o <= raw ^ invert;
    end

    // Byte select by shifting; byte indices past the register width fall off to zero.
    function automatic logic [7:0] byte_sel(input logic [31:0] value,
                                            input logic [pBYTECNT_SIZE-1:0] bc);
        logic [31:0] shifted;
        shifted = value >> {bc, 3'b000};
        return shifted[7:0];
    endfunction

    always_comb begin
        reg_datao = 8'h00;
        if (rd_ok) begin
            case (reg_address)
                pADDR_MODE:    reg_datao = byte_sel(32'(mode), reg_bytecnt);
                pADDR_INVERT:  reg_datao = byte_sel(32'(invert), reg_bytecnt);
                pADDR_STRETCH: reg_datao = byte_sel(32'(stretch_len), reg_bytecnt);
                pADDR_BLINK:   reg_datao = byte_sel(32'(blink_sel), reg_bytecnt);
                default:       reg_datao = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Randomised scoreboard bench for led_status_ctrl: a cycle-level reference model pushes the
// expected reg_datao and led_o into queues that independent monitors drain and compare.
module tb_led_status_ctrl;

    localparam int NL = 4;
    localparam int CW = 8;
    localparam int TL = 4;
    localparam logic [5:0] A_MODE    = 6'h30;
    localparam logic [5:0] A_INVERT  = 6'h31;
    localparam logic [5:0] A_STRETCH = 6'h32;
    localparam logic [5:0] A_BLINK   = 6'h33;

    logic          clk_usb = 1'b0;
    logic          reset_n = 1'b0;
    logic [5:0]    reg_address = '0;
    logic [6:0]    reg_bytecnt = '0;
    logic [7:0]    reg_datai = '0;
    logic [7:0]    reg_datao;
    logic          reg_read = 1'b0;
    logic          reg_write = 1'b0;
    logic          reg_addrvalid = 1'b0;
    logic [NL-1:0] event_i = '0;
    logic [NL-1:0] led_o;

    always #5 clk_usb = ~clk_usb;

    led_status_ctrl #(
        .pNUM_LEDS(NL), .pCNT_WIDTH(CW), .pTICK_LOG2(TL), .pBYTECNT_SIZE(7),
        .pADDR_MODE(A_MODE), .pADDR_INVERT(A_INVERT),
        .pADDR_STRETCH(A_STRETCH), .pADDR_BLINK(A_BLINK)
    ) dut (
        .clk_usb(clk_usb), .reset_n(reset_n), .reg_address(reg_address),
        .reg_bytecnt(reg_bytecnt), .reg_datai(reg_datai), .reg_datao(reg_datao),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
        .event_i(event_i), .led_o(led_o)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [7:0]    rd_q[$];
    logic [NL-1:0] led_q[$];

    // Reference model: cycles since reset, register contents, and per-LED stretch history
    // kept as "length loaded at last event" plus "ticks seen since then".
    int cycles_m;
    int mode_m[NL];
    bit inv_m[NL];
    int stretch_m;
    int blink_m;
    bit act_m[NL];
    int load_m[NL];
    int ticks_m[NL];

    function automatic void modelReset();
        cycles_m  = 0;
        stretch_m = 100;
        blink_m   = CW - 1;
        for (int i = 0; i < NL; i++) begin
            mode_m[i]  = 2;
            inv_m[i]   = 1'b0;
            act_m[i]   = 1'b0;
            load_m[i]  = 0;
            ticks_m[i] = 0;
        end
    endfunction

    function automatic int regValue(input logic [5:0] addr, input int bc);
        int v = 0;
        if (addr == A_MODE) begin
            for (int i = 0; i < NL; i++) v += mode_m[i] << (2 * i);
            return (bc < 4) ? ((v >> (8 * bc)) & 255) : 0;
        end
        if (addr == A_INVERT) begin
            for (int i = 0; i < NL; i++) v += int'(inv_m[i]) << i;
            return (bc < 4) ? ((v >> (8 * bc)) & 255) : 0;
        end
        if (addr == A_STRETCH) begin
            if (bc == 0) return stretch_m & 255;
            if (bc == 1) return (stretch_m >> 8) & 255;
            return 0;
        end
        if (addr == A_BLINK) return (bc == 0) ? blink_m : 0;
        return 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst_n, input bit wr, input bit rd, input bit av,
                                 input logic [5:0] addr, input int bc, input logic [7:0] di,
                                 input logic [NL-1:0] ev);
        logic [NL-1:0] led_exp;
        int  new_mode[NL];
        int  eff;
        bit  lit;
        bit  tick;
        @(negedge clk_usb);
        reset_n       = rst_n;
        reg_write     = wr;
        reg_read      = rd;
        reg_addrvalid = av;
        reg_address   = addr;
        reg_bytecnt   = 7'(bc);
        reg_datai     = di;
        event_i       = ev;

        rd_q.push_back((rd && av) ? 8'(regValue(addr, bc)) : 8'h00);

        led_exp = '0;
        eff = (blink_m > CW - 1) ? CW - 1 : blink_m;
        for (int i = 0; i < NL; i++) begin
            lit = 1'b0;
            case (mode_m[i])
                1: lit = 1'b1;
                2: lit = ((cycles_m % (1 << CW)) >> eff) & 1;
                3: lit = ev[i] || (act_m[i] && ticks_m[i] < load_m[i]);
                default: lit = 1'b0;
            endcase
            led_exp[i] = rst_n ? (lit ^ inv_m[i]) : 1'b0;
        end
        led_q.push_back(led_exp);

        if (!rst_n) begin
            modelReset();
        end else begin
            tick = ((cycles_m % (1 << TL)) == 0);
            new_mode = mode_m;
            if (wr && av && addr == A_MODE)
                for (int i = 0; i < NL; i++)
                    if ((2 * i) / 8 == bc) new_mode[i] = (int'(di) >> ((2 * i) % 8)) & 3;
            for (int i = 0; i < NL; i++) begin
                if (mode_m[i] == 3 && new_mode[i] != 3) begin
                    act_m[i] = 1'b0;
                end else if (mode_m[i] == 3 && ev[i]) begin
                    act_m[i]   = 1'b1;
                    load_m[i]  = stretch_m;
                    ticks_m[i] = 0;
                end else if (tick && act_m[i] && ticks_m[i] < load_m[i]) begin
                    ticks_m[i]++;
                end
            end
            mode_m = new_mode;
            if (wr && av && addr == A_INVERT)
                for (int i = 0; i < NL; i++)
                    if (i / 8 == bc) inv_m[i] = di[i % 8];
            if (wr && av && addr == A_STRETCH) begin
                if (bc == 0) stretch_m = (stretch_m & 16'hFF00) | int'(di);
                if (bc == 1) stretch_m = (stretch_m & 16'h00FF) | (int'(di) << 8);
            end
            if (wr && av && addr == A_BLINK && bc == 0) blink_m = int'(di) & 31;
            cycles_m++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 6'h00, 0, 8'h00, '0);
    endtask

    task automatic writeReg(input logic [5:0] addr, input int bc, input logic [7:0] di);
        applyStimulus(1, 1, 0, 1, addr, bc, di, '0);
    endtask

    task automatic readReg(input logic [5:0] addr, input int bc);
        applyStimulus(1, 0, 1, 1, addr, bc, 8'h00, '0);
    endtask

    // Monitors: read data is combinational, LED state is checked just after each edge.
    initial begin
        logic [7:0] exp_rd;
        forever begin
            @(negedge clk_usb);
            #2;
            if (rd_q.size() > 0) begin
                exp_rd = rd_q.pop_front();
                checkOutput("reg_datao", int'(reg_datao), int'(exp_rd));
            end
        end
    end

    initial begin
        logic [NL-1:0] exp_led;
        forever begin
            @(posedge clk_usb);
            #1;
            if (led_q.size() > 0) begin
                exp_led = led_q.pop_front();
                checkOutput("led_o", int'(led_o), int'(exp_led));
            end
        end
    end

    initial begin
        logic [5:0] addr;
        int         bc;
        logic [7:0] di;
        logic [NL-1:0] ev;
        int         r;

        modelReset();
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 6'h00, 0, 8'h00, '0);

        readReg(A_MODE, 0);
        readReg(A_MODE, 1);
        readReg(A_INVERT, 0);
        readReg(A_STRETCH, 0);
        readReg(A_STRETCH, 1);
        readReg(A_BLINK, 0);
        idle(300);

        writeReg(A_MODE, 0, 8'b11_10_01_00);
        writeReg(A_INVERT, 0, 8'h01);
        writeReg(A_STRETCH, 0, 8'd3);
        writeReg(A_STRETCH, 1, 8'd0);
        idle(5);
        applyStimulus(1, 0, 0, 0, 6'h00, 0, 8'h00, 4'b1000);
        idle(20);
        applyStimulus(1, 0, 0, 0, 6'h00, 0, 8'h00, 4'b1000);
        idle(60);

        writeReg(A_BLINK, 0, 8'd31);
        readReg(A_BLINK, 0);
        idle(300);
        readReg(6'h05, 0);
        applyStimulus(1, 1, 0, 0, A_MODE, 0, 8'h00, '0);
        applyStimulus(1, 0, 1, 0, A_MODE, 0, 8'h00, '0);
        readReg(A_MODE, 0);

        writeReg(A_STRETCH, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 6'h00, 0, 8'h00, 4'b1000);
        idle(3);
        writeReg(A_STRETCH, 0, 8'd5);
        applyStimulus(1, 0, 0, 0, 6'h00, 0, 8'h00, 4'b1000);
        idle(10);
        writeReg(A_MODE, 0, 8'b00_10_01_00);
        idle(3);
        writeReg(A_MODE, 0, 8'b11_10_01_00);
        idle(3);

        applyStimulus(1, 0, 0, 0, 6'h00, 0, 8'h00, 4'b1000);
        idle(30);
        applyStimulus(0, 1, 0, 1, A_BLINK, 0, 8'd2, '0);
        applyStimulus(0, 1, 0, 1, A_MODE, 0, 8'h55, '0);
        readReg(A_MODE, 0);
        readReg(A_BLINK, 0);
        readReg(A_STRETCH, 0);
        idle(10);

        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 9);
            addr = (r < 3) ? A_MODE : (r < 5) ? A_INVERT : (r < 7) ? A_STRETCH :
                   (r < 9) ? A_BLINK : 6'($urandom_range(0, 63));
            bc = ($urandom_range(0, 19) == 0) ? 100 : $urandom_range(0, 3);
            di = 8'($urandom);
            if (addr == A_STRETCH && bc == 0) di = 8'($urandom_range(0, 6));
            if (addr == A_STRETCH && bc == 1) di = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
            for (int i = 0; i < NL; i++) ev[i] = ($urandom_range(0, 9) == 0);
            applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
                          addr, bc, di, ev);
        end

        @(negedge clk_usb);
        @(posedge clk_usb);
        #3;
        checkOutput("read_queue_drained", rd_q.size(), 0);
        checkOutput("led_queue_drained", led_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
